// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA constants and types.
//   INSTR_WIDTH        - instruction word width
//   RCS_NUM_CREG(_LOG2) - configuration entries per context and address width
//   CONF_NUM_CTX       - default number of configuration contexts per cell
//   CONF_CTX_W         - context-id width (at least 1 bit)
//   ctx_id_t           - context identifier at the default width
//   conf_sw_state_e    - context-switch controller states
package cgra_pkg;

    localparam int INSTR_WIDTH       = 32;
    localparam int RCS_NUM_CREG      = 32;
    localparam int RCS_NUM_CREG_LOG2 = $clog2(RCS_NUM_CREG);

    localparam int CONF_NUM_CTX = 2;
    localparam int CONF_CTX_W   = (CONF_NUM_CTX > 1) ? $clog2(CONF_NUM_CTX) : 1;

    typedef logic [CONF_CTX_W-1:0] ctx_id_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } conf_sw_state_e;

endpackage

// File: rtl/conf_ctx_reg_file_sw_ctrl.sv
// conf_ctx_sw_ctrl: context-switch controller for the configuration register file.
// Latches a requested context id, waits for a kernel boundary (run low, or a
// PC-0 fetch) and then makes it the active context.
// Ports:
//   clk, srst           clock and synchronous active-high reset
//   ce                  cell enable; nothing changes and no pulse is raised when low
//   run, re, pc_zero    kernel running / fetch enable / fetch at PC 0
//   sw_req, sw_ctx      switch request pulse and requested context
//   apply, apply_ctx    switch is being applied this cycle, and to which context
//   active_ctx          current active context
//   sw_ack, sw_err      one-cycle pulses: switch applied / request rejected
module conf_ctx_sw_ctrl
    import cgra_pkg::*;
#(
    parameter int NUM_CTX = CONF_NUM_CTX,
    parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ce,
    input  logic             run,
    input  logic             re,
    input  logic             pc_zero,
    input  logic             sw_req,
    input  logic [CTX_W-1:0] sw_ctx,
    output logic             apply,
    output logic [CTX_W-1:0] apply_ctx,
    output logic [CTX_W-1:0] active_ctx,
    output logic             sw_ack,
    output logic             sw_err
);

    // One extra bit so the range check also works when NUM_CTX == 2**CTX_W.
    localparam logic [CTX_W:0] NUM_CTX_L = (CTX_W+1)'(NUM_CTX);

    conf_sw_state_e   state_reg, state_next;
    logic [CTX_W-1:0] pend_reg, pend_next;
    logic [CTX_W-1:0] active_reg, active_next;
    logic             ack_reg, ack_next;
    logic             err_reg, err_next;

    logic req_valid;
    logic req_invalid;

    assign req_valid   = sw_req && ce && ({1'b0, sw_ctx} < NUM_CTX_L);
    assign req_invalid = sw_req && ce && !({1'b0, sw_ctx} < NUM_CTX_L);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= IDLE;
            pend_reg   <= '0;
            active_reg <= '0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pend_reg   <= pend_next;
            active_reg <= active_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pend_next   = pend_reg;
        active_next = active_reg;
        ack_next    = 1'b0;
        err_next    = req_invalid;
        apply       = 1'b0;
        // A valid request arriving while pending replaces the latched id, even
        // in the cycle the switch lands, so the newest request always wins.
        apply_ctx   = req_valid ? sw_ctx : pend_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    pend_next  = sw_ctx;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                apply = ce && (!run || (re && pc_zero));
                if (apply) begin
                    active_next = apply_ctx;
                    ack_next    = 1'b1;
                    state_next  = IDLE;
                end else begin
                    pend_next = apply_ctx;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign active_ctx = active_reg;
    assign sw_ack     = ack_reg;
    assign sw_err     = err_reg;

endmodule

// File: rtl/conf_ctx_reg_file.sv
// conf_ctx_reg_file: multi-context configuration register file for one CGRA cell.
// NUM_CTX banks of NUM_CREG instructions; the active bank is read at the global
// PC with one registered cycle, inactive banks can be written while a kernel runs,
// and bank switches take effect only at a kernel boundary.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   ce_i                     cell enable for reads, writes and switch application
//   run_i                    kernel executing
//   pc_i, re_i               read address and read enable
//   conf_o, conf_valid_o     registered instruction, updated-this-cycle flag
//   we_i, wr_ctx_i, wr_addr_i, wr_instr_i   host write port
//   wr_err_o                 pulse: write rejected
//   sw_req_i, sw_ctx_i       context-switch request
//   sw_ack_o, sw_err_o       pulses: switch applied / rejected
//   active_ctx_o             current active context
module conf_ctx_reg_file #(
    parameter int INSTR_WIDTH = cgra_pkg::INSTR_WIDTH,
    parameter int NUM_CREG    = cgra_pkg::RCS_NUM_CREG,
    parameter int NUM_CTX     = cgra_pkg::CONF_NUM_CTX,
    parameter int CREG_W      = $clog2(NUM_CREG),
    parameter int CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ce_i,
    input  logic                   run_i,
    input  logic [CREG_W-1:0]      pc_i,
    input  logic                   re_i,
    output logic [INSTR_WIDTH-1:0] conf_o,
    output logic                   conf_valid_o,
    input  logic                   we_i,
    input  logic [CTX_W-1:0]       wr_ctx_i,
    input  logic [CREG_W-1:0]      wr_addr_i,
    input  logic [INSTR_WIDTH-1:0] wr_instr_i,
    output logic                   wr_err_o,
    input  logic                   sw_req_i,
    input  logic [CTX_W-1:0]       sw_ctx_i,
    output logic                   sw_ack_o,
    output logic                   sw_err_o,
    output logic [CTX_W-1:0]       active_ctx_o
);

    localparam logic [CTX_W:0] NUM_CTX_L = (CTX_W+1)'(NUM_CTX);

    logic [INSTR_WIDTH-1:0] mem [NUM_CTX][NUM_CREG];

    logic [INSTR_WIDTH-1:0] conf_reg;
    logic                   conf_valid_reg;
    logic                   wr_err_reg;

    logic             apply;
    logic [CTX_W-1:0] apply_ctx;
    logic [CTX_W-1:0] active_ctx;
    logic [CTX_W-1:0] eff_ctx;
    logic             rd_en;
    logic             wr_en;

    conf_ctx_sw_ctrl #(
        .NUM_CTX (NUM_CTX),
        .CTX_W   (CTX_W)
    ) u_sw_ctrl (
        .clk        (clk_i),
        .srst       (rst_i),
        .ce         (ce_i),
        .run        (run_i),
        .re         (re_i),
        .pc_zero    (pc_i == '0),
        .sw_req     (sw_req_i),
        .sw_ctx     (sw_ctx_i),
        .apply      (apply),
        .apply_ctx  (apply_ctx),
        .active_ctx (active_ctx),
        .sw_ack     (sw_ack_o),
        .sw_err     (sw_err_o)
    );

    // The PC-0 fetch that lands a switch already reads the incoming bank.
    assign eff_ctx = apply ? apply_ctx : active_ctx;
    assign rd_en   = re_i && ce_i;

    // The protection check uses the pre-switch active bank, so in an apply
    // cycle the outgoing bank is still locked and the incoming one is open.
    assign wr_en = we_i && ce_i && ({1'b0, wr_ctx_i} < NUM_CTX_L)
                   && !(run_i && (wr_ctx_i == active_ctx));

    // Storage: no reset, contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ctx_i][wr_addr_i] <= wr_instr_i;
        end
    end

    // Registered read; a same-cycle write to the same entry is seen next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conf_reg       <= '0;
            conf_valid_reg <= 1'b0;
            wr_err_reg     <= 1'b0;
        end else begin
            conf_valid_reg <= rd_en;
            wr_err_reg     <= we_i && ce_i && !wr_en;
            if (rd_en) begin
                conf_reg <= mem[eff_ctx][pc_i];
            end
        end
    end

    assign conf_o       = conf_reg;
    assign conf_valid_o = conf_valid_reg;
    assign wr_err_o     = wr_err_reg;
    assign active_ctx_o = active_ctx;

endmodule

// File: tb/tb_conf_ctx_reg_file.sv
module tb_conf_ctx_reg_file;

    localparam int IW   = 32;
    localparam int NCR  = 32;
    localparam int NCTX = 3;
    localparam int CRW  = 5;
    localparam int CTW  = 2;

    logic           clk = 1'b0;
    logic           rst_i, ce_i, run_i, re_i, we_i, sw_req_i;
    logic [CRW-1:0] pc_i, wr_addr_i;
    logic [CTW-1:0] wr_ctx_i, sw_ctx_i;
    logic [IW-1:0]  wr_instr_i;
    logic [IW-1:0]  conf_o;
    logic           conf_valid_o, wr_err_o, sw_ack_o, sw_err_o;
    logic [CTW-1:0] active_ctx_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [IW-1:0] mdl_mem [NCTX][NCR];
    logic [IW-1:0] exp_conf;
    bit            exp_valid, exp_wr_err, exp_ack, exp_sw_err;
    int            exp_active;
    bit            mdl_pending;
    int            mdl_pend_id;

    always #5 clk = ~clk;

    conf_ctx_reg_file #(
        .INSTR_WIDTH (IW),
        .NUM_CREG    (NCR),
        .NUM_CTX     (NCTX)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ce_i         (ce_i),
        .run_i        (run_i),
        .pc_i         (pc_i),
        .re_i         (re_i),
        .conf_o       (conf_o),
        .conf_valid_o (conf_valid_o),
        .we_i         (we_i),
        .wr_ctx_i     (wr_ctx_i),
        .wr_addr_i    (wr_addr_i),
        .wr_instr_i   (wr_instr_i),
        .wr_err_o     (wr_err_o),
        .sw_req_i     (sw_req_i),
        .sw_ctx_i     (sw_ctx_i),
        .sw_ack_o     (sw_ack_o),
        .sw_err_o     (sw_err_o),
        .active_ctx_o (active_ctx_o)
    );

    task automatic idle_inputs();
        rst_i = 0; ce_i = 1; re_i = 0; we_i = 0; sw_req_i = 0;
        pc_i = '0; wr_addr_i = '0; wr_ctx_i = '0; sw_ctx_i = '0; wr_instr_i = '0;
    endtask

    // Advance one clock; predict from the rules what the outputs become.
    task automatic cycle();
        bit            rd, sw_ok, do_apply, wr_ok;
        int            target, eff;
        logic [IW-1:0] rd_val;
        rd       = re_i && ce_i;
        sw_ok    = sw_req_i && ce_i && (int'(sw_ctx_i) < NCTX);
        do_apply = ce_i && mdl_pending && (!run_i || (re_i && pc_i == 0));
        target   = (mdl_pending && sw_ok) ? int'(sw_ctx_i) : mdl_pend_id;
        eff      = do_apply ? target : exp_active;
        rd_val   = mdl_mem[eff][pc_i];
        wr_ok    = we_i && ce_i && (int'(wr_ctx_i) < NCTX)
                   && !(run_i && int'(wr_ctx_i) == exp_active);
        @(posedge clk);
        #1;
        if (wr_ok) mdl_mem[wr_ctx_i][wr_addr_i] = wr_instr_i;
        if (rst_i) begin
            exp_conf = '0; exp_valid = 0; exp_wr_err = 0; exp_ack = 0; exp_sw_err = 0;
            exp_active = 0; mdl_pending = 0; mdl_pend_id = 0;
        end else begin
            exp_valid  = rd;
            if (rd) exp_conf = rd_val;
            exp_wr_err = we_i && ce_i && !wr_ok;
            exp_sw_err = sw_req_i && ce_i && !(int'(sw_ctx_i) < NCTX);
            exp_ack    = do_apply;
            if (do_apply) begin
                exp_active  = target;
                mdl_pending = 0;
            end else if (sw_ok) begin
                mdl_pending = 1;
                mdl_pend_id = int'(sw_ctx_i);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1;
        cycle();
        rst_i = 0;
        n_tests++; if (conf_o !== '0) begin n_fail++; $display("FAIL reset_conf: got %h want 0", conf_o); end
        n_tests++; if (conf_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", conf_valid_o); end
        n_tests++; if (wr_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b want 0", wr_err_o); end
        n_tests++; if (sw_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", sw_ack_o); end
        n_tests++; if (sw_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_sw_err: got %b want 0", sw_err_o); end
        n_tests++; if (active_ctx_o !== '0) begin n_fail++; $display("FAIL reset_active: got %0d want 0", active_ctx_o); end
        $display("[TB] reset checked");
    endtask

    task automatic preload_all();
        idle_inputs();
        run_i = 0;
        for (int c = 0; c < NCTX; c++) begin
            for (int a = 0; a < NCR; a++) begin
                we_i = 1; wr_ctx_i = CTW'(c); wr_addr_i = CRW'(a); wr_instr_i = $urandom;
                cycle();
            end
        end
        idle_inputs();
        $display("[TB] preloaded %0d entries", NCTX * NCR);
    endtask

    task automatic test_preload_read();
        idle_inputs(); run_i = 0;
        we_i = 1; wr_ctx_i = 0; wr_addr_i = 3; wr_instr_i = 32'hDEADBEEF;
        cycle();
        n_tests++; if (wr_err_o !== 1'b0) begin n_fail++; $display("FAIL preload_wr_err: got %b want 0", wr_err_o); end
        idle_inputs(); re_i = 1; pc_i = 3;
        cycle();
        idle_inputs();
        n_tests++; if (conf_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL preload_conf: got %h want deadbeef", conf_o); end
        n_tests++; if (conf_valid_o !== 1'b1) begin n_fail++; $display("FAIL preload_valid: got %b want 1", conf_valid_o); end
        n_tests++; if (active_ctx_o !== 0) begin n_fail++; $display("FAIL preload_active: got %0d want 0", active_ctx_o); end
        $display("[TB] preload/read conf=%h", conf_o);
    endtask

    task automatic test_protected_write();
        logic [IW-1:0] old_val;
        old_val = mdl_mem[0][1];
        idle_inputs(); run_i = 1;
        we_i = 1; wr_ctx_i = 0; wr_addr_i = 1; wr_instr_i = 32'h11;
        cycle();
        n_tests++; if (wr_err_o !== 1'b1) begin n_fail++; $display("FAIL protect_err_active: got %b want 1", wr_err_o); end
        wr_ctx_i = 1; wr_instr_i = 32'h22;
        cycle();
        n_tests++; if (wr_err_o !== 1'b0) begin n_fail++; $display("FAIL protect_err_inactive: got %b want 0", wr_err_o); end
        wr_addr_i = 0;                      // ctx1[0] = 0x22 for the boundary switch
        cycle();
        idle_inputs(); re_i = 1; pc_i = 1;  // active ctx0 read while running is fine
        cycle();
        idle_inputs();
        n_tests++; if (conf_o !== old_val) begin n_fail++; $display("FAIL protect_mem_unchanged: got %h want %h", conf_o, old_val); end
        $display("[TB] protected write ctx0[1]=%h", conf_o);
    endtask

    task automatic test_boundary_switch();
        idle_inputs(); run_i = 1;
        sw_req_i = 1; sw_ctx_i = 1;
        cycle();
        idle_inputs();
        for (int p = 5; p <= 7; p++) begin
            re_i = 1; pc_i = CRW'(p);
            cycle();
            n_tests++; if (conf_o !== mdl_mem[0][p]) begin n_fail++; $display("FAIL boundary_pc%0d: got %h want %h", p, conf_o, mdl_mem[0][p]); end
            n_tests++; if (sw_ack_o !== 1'b0) begin n_fail++; $display("FAIL boundary_early_ack pc%0d: got %b want 0", p, sw_ack_o); end
        end
        pc_i = 0;
        cycle();
        idle_inputs();
        n_tests++; if (conf_o !== 32'h22) begin n_fail++; $display("FAIL boundary_pc0: got %h want 22", conf_o); end
        n_tests++; if (sw_ack_o !== 1'b1) begin n_fail++; $display("FAIL boundary_ack: got %b want 1", sw_ack_o); end
        n_tests++; if (active_ctx_o !== 1) begin n_fail++; $display("FAIL boundary_active: got %0d want 1", active_ctx_o); end
        cycle();
        n_tests++; if (sw_ack_o !== 1'b0) begin n_fail++; $display("FAIL boundary_ack_once: got %b want 0", sw_ack_o); end
        $display("[TB] boundary switch active=%0d", active_ctx_o);
    endtask

    task automatic test_overwrite_reject();
        int acks = 0;
        idle_inputs(); run_i = 1;
        for (int k = 1; k <= 3; k++) begin
            sw_req_i = 1; sw_ctx_i = CTW'(k);
            cycle();
            acks += int'(sw_ack_o);
            if (k < 3) begin
                n_tests++; if (sw_err_o !== 1'b0) begin n_fail++; $display("FAIL overwrite_err_ctx%0d: got %b want 0", k, sw_err_o); end
            end
        end
        n_tests++; if (sw_err_o !== 1'b1) begin n_fail++; $display("FAIL overwrite_err_ctx3: got %b want 1", sw_err_o); end
        idle_inputs(); re_i = 1; pc_i = 0;
        cycle();
        acks += int'(sw_ack_o);
        idle_inputs();
        cycle();
        acks += int'(sw_ack_o);
        n_tests++; if (active_ctx_o !== 2) begin n_fail++; $display("FAIL overwrite_active: got %0d want 2", active_ctx_o); end
        n_tests++; if (acks != 1) begin n_fail++; $display("FAIL overwrite_ack_count: got %0d want 1", acks); end
        $display("[TB] overwrite/reject active=%0d acks=%0d", active_ctx_o, acks);
    endtask

    task automatic test_read_before_write();
        idle_inputs(); run_i = 0;
        sw_req_i = 1; sw_ctx_i = 0;
        cycle();
        idle_inputs();
        cycle();
        n_tests++; if (sw_ack_o !== 1'b1) begin n_fail++; $display("FAIL rbw_switch_ack: got %b want 1", sw_ack_o); end
        we_i = 1; wr_ctx_i = 0; wr_addr_i = 4; wr_instr_i = 32'hA;
        cycle();
        re_i = 1; pc_i = 4; wr_instr_i = 32'hB;
        cycle();
        n_tests++; if (conf_o !== 32'hA) begin n_fail++; $display("FAIL rbw_old: got %h want a", conf_o); end
        we_i = 0;
        cycle();
        idle_inputs();
        n_tests++; if (conf_o !== 32'hB) begin n_fail++; $display("FAIL rbw_new: got %h want b", conf_o); end
        $display("[TB] read-before-write conf=%h", conf_o);
    endtask

    task automatic test_reset_ce();
        int acks = 0;
        idle_inputs(); run_i = 1;
        sw_req_i = 1; sw_ctx_i = 1;
        cycle();
        idle_inputs(); rst_i = 1;
        cycle();
        acks += int'(sw_ack_o);
        idle_inputs(); run_i = 0;
        cycle(); acks += int'(sw_ack_o);
        cycle(); acks += int'(sw_ack_o);
        n_tests++; if (acks != 0) begin n_fail++; $display("FAIL rst_pending_ack: got %0d want 0", acks); end
        n_tests++; if (active_ctx_o !== 0) begin n_fail++; $display("FAIL rst_active: got %0d want 0", active_ctx_o); end
        re_i = 1; pc_i = 4;
        cycle();
        n_tests++; if (conf_o !== 32'hB) begin n_fail++; $display("FAIL rst_mem_kept: got %h want b", conf_o); end
        // ce low: everything requested, nothing may happen
        ce_i = 0; we_i = 1; wr_ctx_i = 0; wr_addr_i = 4; wr_instr_i = 32'hC;
        sw_req_i = 1; sw_ctx_i = 1; re_i = 1; pc_i = 0;
        cycle();
        n_tests++; if (conf_valid_o !== 1'b0) begin n_fail++; $display("FAIL ce_valid: got %b want 0", conf_valid_o); end
        n_tests++; if (conf_o !== 32'hB) begin n_fail++; $display("FAIL ce_conf_hold: got %h want b", conf_o); end
        n_tests++; if ({wr_err_o, sw_err_o, sw_ack_o} !== 3'b000) begin n_fail++; $display("FAIL ce_pulses: got %b want 000", {wr_err_o, sw_err_o, sw_ack_o}); end
        sw_ctx_i = 3; wr_ctx_i = 3;
        cycle();
        n_tests++; if ({wr_err_o, sw_err_o} !== 2'b00) begin n_fail++; $display("FAIL ce_err_pulses: got %b want 00", {wr_err_o, sw_err_o}); end
        idle_inputs();
        cycle();
        n_tests++; if (sw_ack_o !== 1'b0 || active_ctx_o !== 0) begin n_fail++; $display("FAIL ce_no_switch: ack %b active %0d want 0/0", sw_ack_o, active_ctx_o); end
        re_i = 1; pc_i = 4;
        cycle();
        idle_inputs();
        n_tests++; if (conf_o !== 32'hB) begin n_fail++; $display("FAIL ce_no_write: got %h want b", conf_o); end
        $display("[TB] reset mid-pending and ce gating checked");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_i      = ($urandom_range(0, 199) == 0);
            ce_i       = ($urandom_range(0, 7) != 0);
            run_i      = $urandom_range(0, 1) == 1;
            re_i       = ($urandom_range(0, 9) < 7);
            pc_i       = ($urandom_range(0, 3) == 0) ? '0 : CRW'($urandom_range(0, NCR-1));
            we_i       = !rst_i && ($urandom_range(0, 9) < 4);
            wr_ctx_i   = CTW'($urandom_range(0, 3));
            wr_addr_i  = CRW'($urandom_range(0, NCR-1));
            wr_instr_i = $urandom;
            sw_req_i   = ($urandom_range(0, 99) < 15);
            sw_ctx_i   = CTW'($urandom_range(0, 3));
            cycle();
            n_tests++; if (conf_valid_o !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc%0d: got %b want %b", i, conf_valid_o, exp_valid); end
            n_tests++; if (conf_o !== exp_conf) begin n_fail++; $display("FAIL rnd_conf cyc%0d: got %h want %h", i, conf_o, exp_conf); end
            n_tests++; if (wr_err_o !== exp_wr_err) begin n_fail++; $display("FAIL rnd_wr_err cyc%0d: got %b want %b", i, wr_err_o, exp_wr_err); end
            n_tests++; if (sw_ack_o !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc%0d: got %b want %b", i, sw_ack_o, exp_ack); end
            n_tests++; if (sw_err_o !== exp_sw_err) begin n_fail++; $display("FAIL rnd_sw_err cyc%0d: got %b want %b", i, sw_err_o, exp_sw_err); end
            n_tests++; if (int'(active_ctx_o) != exp_active) begin n_fail++; $display("FAIL rnd_active cyc%0d: got %0d want %0d", i, active_ctx_o, exp_active); end
        end
        idle_inputs();
        $display("[TB] random phase done, active=%0d", active_ctx_o);
    endtask

    initial begin
        idle_inputs();
        run_i = 0;
        exp_conf = '0; exp_valid = 0; exp_wr_err = 0; exp_ack = 0; exp_sw_err = 0;
        exp_active = 0; mdl_pending = 0; mdl_pend_id = 0;
        test_reset();
        preload_all();
        test_preload_read();
        test_protected_write();
        test_boundary_switch();
        test_overwrite_reject();
        test_read_before_write();
        test_reset_ce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conf_ctx_reg_file.md
Name: conf_ctx_reg_file

Overview:
- Multi-context configuration register file for one reconfigurable cell (RC) of the CGRA.
- Holds NUM_CTX independent instruction banks of NUM_CREG entries each.
- Serves the instruction addressed by the global PC from the active bank, with one registered read cycle.
- Lets the host preload an inactive bank while a kernel runs, then swaps banks only at a kernel boundary, so reconfiguration overlaps execution.

Parameters:
- INSTR_WIDTH, 32, instruction word width in bits.
- NUM_CREG, 32, entries per context; must be at least 2.
- NUM_CTX, 2, number of context banks; must be at least 1.
- CREG_W, $clog2(NUM_CREG), derived PC/address width.
- CTX_W, max(1,$clog2(NUM_CTX)), derived context-id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- ce_i  in  1  cell enable; gates reads, writes and switch application.
- run_i  in  1  kernel executing.
- pc_i  in  CREG_W  global PC, the read address.
- re_i  in  1  read enable.
- conf_o  out  INSTR_WIDTH  registered instruction.
- conf_valid_o  out  1  conf_o was updated by a read this cycle.
- we_i  in  1  write request.
- wr_ctx_i  in  CTX_W  target context.
- wr_addr_i  in  CREG_W  target entry.
- wr_instr_i  in  INSTR_WIDTH  write data.
- wr_err_o  out  1  one-cycle pulse: write rejected.
- sw_req_i  in  1  context-switch request (single-cycle pulse).
- sw_ctx_i  in  CTX_W  requested context.
- sw_ack_o  out  1  one-cycle pulse: switch applied.
- sw_err_o  out  1  one-cycle pulse: switch rejected.
- active_ctx_o  out  CTX_W  current active context.

Behaviour:
- Reset values: conf_o=0, conf_valid_o=0, wr_err_o=0, sw_ack_o=0, sw_err_o=0, active_ctx_o=0; pending switch cleared; FSM goes to IDLE.
- Memory has no reset. Contents persist across rst_i.
- Clock gating: none. Writes use a plain enable on clk_i.
- Outputs when ce_i=0:
  - no read, write or switch takes effect;
  - pending request is held;
  - error and ack pulses are 0;
  - conf_o holds its value.
- Write rules:
  - Write executes when we_i&&ce_i, wr_ctx_i<NUM_CTX, and not (run_i && wr_ctx_i==active context).
  - Otherwise, if we_i&&ce_i, the write is dropped and wr_err_o pulses the next cycle.
  - Data is visible to reads from the following cycle.
- Read rules:
  - When re_i&&ce_i: conf_o <= mem[effective_ctx][pc_i] and conf_valid_o=1 in the next cycle.
  - Otherwise conf_valid_o=0.
  - Latency is 1.
  - Read and write to the same entry in the same cycle: the read returns the old data.
- FSM states IDLE and PENDING:
  - IDLE: on sw_req_i&&ce_i with sw_ctx_i<NUM_CTX, latch sw_ctx_i and go to PENDING.
  - IDLE: with sw_ctx_i>=NUM_CTX, pulse sw_err_o and stay in IDLE.
  - PENDING: a new valid sw_req_i overwrites the latched id. Still exactly one ack is issued.
  - PENDING: an invalid new request pulses sw_err_o and keeps the old pending id.
- Switch application (PENDING with ce_i), when either holds:
  - run_i=0;
  - re_i=1 and pc_i==0 (kernel boundary).
- On application:
  - active_ctx_o <= pending id; return to IDLE.
  - sw_ack_o pulses in the cycle after application.
- effective_ctx: equals the pending id in the applying cycle, otherwise active_ctx_o. The PC-0 fetch therefore already reads the new context.
- Simultaneous switch-apply and write:
  - The write's active-context check uses active_ctx_o before the switch.
  - A write to the old context, issued in the apply cycle while run_i=1, is rejected.
  - A write to the incoming context in that same cycle is accepted.
- Requesting a switch to the already-active context is legal. It follows the same path and acks.
- NUM_CTX=1: switch requests to context 0 ack normally. Writes during run_i are always rejected.
- rst_i mid-PENDING: pending request is discarded and no ack is issued.

Decomposition:
- Add to cgra_pkg:
  - NUM_CTX default constant;
  - derived CTX_W;
  - typedef ctx_id_t;
  - typedef conf_sw_state_e {IDLE, PENDING}.
- Reuse the existing INSTR_WIDTH, RCS_NUM_CREG and RCS_NUM_CREG_LOG2 as parameter defaults.
- Natural sub-module: conf_ctx_sw_ctrl, holding the switch FSM, pending register and ack/err generation.
- The parent holds the storage array, write check and read register.

Test Plan:
- Preload then read:
  - Stimulus: reset; run_i=0; write ctx0 addr3=0xDEADBEEF; next cycle re_i, pc_i=3.
  - Response: one cycle later conf_o=0xDEADBEEF and conf_valid_o=1; active_ctx_o=0.
- Protected write:
  - Stimulus: run_i=1, active ctx0; write ctx0 addr1=0x11, and write ctx1 addr1=0x22.
  - Response: the first gives wr_err_o=1 with mem unchanged; the second is accepted with no error.
- Boundary switch:
  - Stimulus: run_i=1; sw_req to ctx1; reads at pc 5,6,7, then pc 0.
  - Response: pc5-7 return ctx0 data. The pc0 read returns ctx1[0]=0x22-preloaded value. sw_ack_o pulses once in the following cycle and active_ctx_o=1.
- Overwrite and reject:
  - Stimulus: NUM_CTX=3; sw_req ctx1, then sw_req ctx2 while pending, then sw_req ctx3.
  - Response: ctx3 gives sw_err_o. The switch lands on ctx2 with a single ack.
- Read-before-write:
  - Stimulus: run_i=0; read and write ctx0 addr4 in the same cycle, old 0xA, new 0xB.
  - Response: conf_o=0xA. The next read gives 0xB.
- Reset and ce:
  - Stimulus: rst_i asserted during PENDING. Separately, ce_i=0 with we_i, re_i, sw_req_i all high.
  - Response: with rst_i, no ack and active_ctx_o=0, while mem contents are retained. With ce_i=0, no state change and all pulses 0.
